// File: rtl/uart_rx_seq.sv
// uart_rx_seq: start-bit validation and frame sequencing for the 16x UART receiver.
// Optional RECV timeout abort enabled by defining UART_RX_SEQ_TIMEOUT_EN.
module uart_rx_seq #(
    parameter int OVS      = 16,
    parameter int HALF_BIT = 8
`ifdef UART_RX_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 200
`endif
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    input  logic [9:0] trama_i,
    input  logic       dato_compl_i,
    output logic       verif_edg_o,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    input  logic       clr_err_i,
    output logic       busy_o
);

    // start counter never runs past one bit time
    localparam int BW = $clog2(OVS) + 1;
    localparam logic [BW-1:0] HB_LAST = BW'(HALF_BIT - 1);

`ifdef UART_RX_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] tcnt;
`endif

    typedef enum logic [2:0] {
        IDLE,
        START,
        RECV,
        CHECK,
        WAIT_IDLE
    } state_t;

    state_t        state;
    logic [BW-1:0] cnt;
    logic          rx_meta;
    logic          rx_s;
    logic          rx_s_prev;
    logic          rx_fall;
    logic          frame_ok;

    assign rx_fall  = rx_s_prev & ~rx_s;
    assign frame_ok = ~trama_i[0] & trama_i[9];

    // two-flop synchronizer plus one delayed copy for edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_s_prev <= 1'b1;
        end else begin
            rx_meta   <= rx_i;
            rx_s      <= rx_meta;
            rx_s_prev <= rx_s;
        end
    end

    // frame sequencer, handshake and sticky error flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            verif_edg_o <= 1'b0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            busy_o      <= 1'b0;
`ifdef UART_RX_SEQ_TIMEOUT_EN
            tcnt        <= '0;
`endif
        end else begin
            // clear first so a set later in this block wins
            if (clr_err_i) begin
                frame_err_o <= 1'b0;
                overrun_o   <= 1'b0;
            end
            if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            case (state)
                IDLE: begin
                    verif_edg_o <= 1'b0;
                    busy_o      <= 1'b0;
                    if (rx_fall) begin
                        state       <= START;
                        cnt         <= '0;
                        verif_edg_o <= 1'b1;
                        busy_o      <= 1'b1;
                    end
                end
                START: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == HB_LAST) begin
                        if (rx_s) begin
                            state       <= IDLE;
                            verif_edg_o <= 1'b0;
                            busy_o      <= 1'b0;
                        end else begin
                            state <= RECV;
`ifdef UART_RX_SEQ_TIMEOUT_EN
                            tcnt  <= '0;
`endif
                        end
                    end
                end
                RECV: begin
                    verif_edg_o <= 1'b1;
                    if (dato_compl_i) begin
                        state       <= CHECK;
                        verif_edg_o <= 1'b0;
                    end
`ifdef UART_RX_SEQ_TIMEOUT_EN
                    else if (tcnt == TO_LAST) begin
                        state       <= WAIT_IDLE;
                        verif_edg_o <= 1'b0;
                        frame_err_o <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                CHECK: begin
                    verif_edg_o <= 1'b0;
                    state       <= WAIT_IDLE;
                    if (frame_ok) begin
                        if (!valid_o || ready_i) begin
                            data_o  <= trama_i[8:1];
                            valid_o <= 1'b1;
                        end else begin
                            overrun_o <= 1'b1;
                        end
                    end else begin
                        frame_err_o <= 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    verif_edg_o <= 1'b0;
                    if (rx_s) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    verif_edg_o <= 1'b0;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_seq.sv
// tb_uart_rx_seq: directed table, random frames against a frame-level model.
// Define UART_RX_SEQ_TIMEOUT_EN to also exercise the RECV timeout.
module tb_uart_rx_seq;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       rx_i;
    logic [9:0] trama_i;
    logic       dato_compl_i;
    logic       verif_edg_o;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overrun_o;
    logic       clr_err_i;
    logic       busy_o;

    uart_rx_seq dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rx_i         (rx_i),
        .trama_i      (trama_i),
        .dato_compl_i (dato_compl_i),
        .verif_edg_o  (verif_edg_o),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o),
        .clr_err_i    (clr_err_i),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int errs   = 0;
    int checks = 0;

    // frame-level reference state
    bit       mvalid;
    bit       mferr;
    bit       movr;
    bit [7:0] mdata;

    typedef struct {
        logic [9:0] t;
        bit         rc;
        bit         cc;
        bit         pop;
        bit         clr;
        bit [7:0]   ed;
        bit         ev;
        bit         ef;
        bit         eo;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_valid"}, 32'(valid_o), 32'(mvalid));
        chk({tag, "_data"}, 32'(data_o), 32'(mdata));
        chk({tag, "_ferr"}, 32'(frame_err_o), 32'(mferr));
        chk({tag, "_ovr"}, 32'(overrun_o), 32'(movr));
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_verif"}, 32'(verif_edg_o), 32'd0);
    endtask

    task automatic wait_verif(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (verif_edg_o) break;
            @(negedge clk_i);
        end
        chk({tag, "_verif_rise"}, 32'(verif_edg_o), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (!busy_o) break;
            @(negedge clk_i);
        end
        chk({tag, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    // plays the pin and the receiver for one frame, then updates the model
    task automatic send_frame(input logic [9:0] t, input bit rc,
                              input bit cc, input int dly);
        bit good;
        @(negedge clk_i);
        rx_i = 1'b0;
        wait_verif("frm");
        repeat (8 + dly) @(negedge clk_i);
        chk("recv_verif", 32'(verif_edg_o), 32'd1);
        chk("recv_busy", 32'(busy_o), 32'd1);
        trama_i      = t;
        dato_compl_i = 1'b1;
        @(negedge clk_i);
        dato_compl_i = 1'b0;
        ready_i      = rc;
        clr_err_i    = cc;
        @(negedge clk_i);
        ready_i   = 1'b0;
        clr_err_i = 1'b0;
        rx_i      = 1'b1;
        chk("post_check_verif", 32'(verif_edg_o), 32'd0);
        wait_idle("frm");
        good = (t[0] == 1'b0) && (t[9] == 1'b1);
        if (cc) begin
            mferr = 1'b0;
            movr  = 1'b0;
        end
        if (good) begin
            if (!mvalid || rc) begin
                mdata  = t[8:1];
                mvalid = 1'b1;
            end else begin
                movr = 1'b1;
            end
        end else begin
            mferr = 1'b1;
            if (mvalid && rc) mvalid = 1'b0;
        end
    endtask

    task automatic pop_byte();
        @(negedge clk_i);
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        mvalid  = 1'b0;
    endtask

    task automatic clr_flags();
        @(negedge clk_i);
        clr_err_i = 1'b1;
        @(negedge clk_i);
        clr_err_i = 1'b0;
        mferr = 1'b0;
        movr  = 1'b0;
    endtask

    function automatic logic [9:0] mk(input bit sp, input bit [7:0] d,
                                      input bit st);
        return {sp, d, st};
    endfunction

    initial begin
        bit seen_busy;
        bit seen_verif;
        int n;

        vt[0] = '{mk(1, 8'hA5, 0), 0, 0, 1, 0, 8'hA5, 1, 0, 0};
        vt[1] = '{mk(0, 8'h5A, 0), 0, 0, 0, 1, 8'hA5, 0, 1, 0};
        vt[2] = '{mk(1, 8'h3C, 0), 0, 0, 0, 0, 8'h3C, 1, 0, 0};
        vt[3] = '{mk(1, 8'hC3, 0), 0, 0, 1, 1, 8'h3C, 1, 0, 1};
        vt[4] = '{mk(1, 8'hFF, 1), 0, 0, 0, 1, 8'h3C, 0, 1, 0};
        vt[5] = '{mk(1, 8'h11, 0), 0, 0, 0, 0, 8'h11, 1, 0, 0};
        vt[6] = '{mk(1, 8'h22, 0), 1, 0, 0, 0, 8'h22, 1, 0, 0};
        vt[7] = '{mk(1, 8'h33, 0), 0, 1, 1, 1, 8'h22, 1, 0, 1};

        rst_i        = 1'b1;
        rx_i         = 1'b1;
        trama_i      = '0;
        dato_compl_i = 1'b0;
        ready_i      = 1'b0;
        clr_err_i    = 1'b0;
        mvalid       = 1'b0;
        mferr        = 1'b0;
        movr         = 1'b0;
        mdata        = 8'h00;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        check_model("reset");
        repeat (50) @(negedge clk_i);
        check_model("idle50");

        // short low pulse: START entered, rejected at mid-bit
        seen_busy  = 1'b0;
        seen_verif = 1'b0;
        rx_i = 1'b0;
        repeat (4) begin
            @(negedge clk_i);
            seen_busy  = seen_busy | busy_o;
            seen_verif = seen_verif | verif_edg_o;
        end
        rx_i = 1'b1;
        chk("glitch_start_busy", 32'(seen_busy), 32'd1);
        chk("glitch_start_verif", 32'(seen_verif), 32'd1);
        repeat (20) @(negedge clk_i);
        check_model("glitch");

        for (int i = 0; i < 8; i++) begin
            send_frame(vt[i].t, vt[i].rc, vt[i].cc, 20 + 10 * i);
            chk($sformatf("vec%0d_valid", i), 32'(valid_o), 32'(vt[i].ev));
            chk($sformatf("vec%0d_data", i), 32'(data_o), 32'(vt[i].ed));
            chk($sformatf("vec%0d_ferr", i), 32'(frame_err_o), 32'(vt[i].ef));
            chk($sformatf("vec%0d_ovr", i), 32'(overrun_o), 32'(vt[i].eo));
            if (vt[i].pop) begin
                pop_byte();
                chk($sformatf("vec%0d_pop", i), 32'(valid_o), 32'd0);
            end
            if (vt[i].clr) begin
                clr_flags();
                chk($sformatf("vec%0d_clr_f", i), 32'(frame_err_o), 32'd0);
                chk($sformatf("vec%0d_clr_o", i), 32'(overrun_o), 32'd0);
            end
        end

        for (int i = 0; i < 25; i++) begin
            bit [7:0] d;
            bit       st;
            bit       sp;
            d  = 8'($urandom);
            st = ($urandom_range(0, 3) == 0);
            sp = ($urandom_range(0, 3) != 0);
            send_frame(mk(sp, d, st), 1'($urandom), 1'($urandom),
                       $urandom_range(1, 120));
            check_model($sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1) pop_byte();
            if ($urandom_range(0, 2) == 0) clr_flags();
            check_model($sformatf("rnd%0d_post", i));
        end

`ifdef UART_RX_SEQ_TIMEOUT_EN
        // receiver never completes: abort after 200 RECV cycles
        @(negedge clk_i);
        rx_i = 1'b0;
        wait_verif("tmo");
        n = 0;
        while (verif_edg_o && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        chk("tmo_len", 32'(n), 32'd208);
        chk("tmo_ferr", 32'(frame_err_o), 32'd1);
        chk("tmo_wait_busy", 32'(busy_o), 32'd1);
        mferr = 1'b1;
        rx_i  = 1'b1;
        wait_idle("tmo");
        check_model("tmo");
`endif

        // reset in the middle of RECV drops the pending byte
        send_frame(mk(1, 8'h77, 0), 0, 0, 5);
        chk("pre_rst_valid", 32'(valid_o), 32'd1);
        @(negedge clk_i);
        rx_i = 1'b0;
        wait_verif("rst");
        repeat (20) @(negedge clk_i);
        chk("rst_recv_verif", 32'(verif_edg_o), 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i  = 1'b0;
        rx_i   = 1'b1;
        mvalid = 1'b0;
        mferr  = 1'b0;
        movr   = 1'b0;
        mdata  = 8'h00;
        check_model("midrst");
        repeat (20) @(negedge clk_i);
        check_model("midrst_idle");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_seq.md
Name: uart_rx_seq

Overview:
Sequencer for the 16x-oversampled UART frame receiver (`recib_datos`).
- Detects a start-bit falling edge on the serial line and validates it at mid-bit.
- Arms the receiver's enable and waits for its frame-complete flag.
- Checks the start and stop bits, then presents the data byte on a valid/ready interface toward the consumer logic.
- Sits between the pin-level rx line plus receiver and the byte consumer.

Parameters:
- OVS, 16, oversampling ticks per bit. Must match the receiver.
- HALF_BIT, 8, cycles after the detected falling edge at which the start bit is re-checked.
- TIMEOUT_CYC, 200, maximum cycles spent in RECV before abort. Used only with the optional feature.

Ports:
- clk_i  in  1  system clock; all logic on posedge.
- rst_i  in  1  synchronous, active-high reset.
- rx_i  in  1  raw asynchronous serial line (idle high).
- trama_i  in  10  frame from receiver: [0] start, [8:1] data LSB-first, [9] stop.
- dato_compl_i  in  1  receiver frame-complete flag.
- verif_edg_o  out  1  receiver enable; low holds the receiver cleared.
- data_o  out  8  received byte.
- valid_o  out  1  data_o holds an unconsumed byte.
- ready_i  in  1  consumer accepts data_o when valid_o & ready_i.
- frame_err_o  out  1  sticky: bad start/stop bit or timeout.
- overrun_o  out  1  sticky: frame completed while valid_o still high.
- clr_err_i  in  1  one-cycle pulse; clears frame_err_o and overrun_o.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Input sync: rx_i passes through a 2-flop synchronizer (rx_s), reset to 1. The previous rx_s is registered for edge detection. A falling edge is rx_s_prev=1 and rx_s=0.
- Reset values: verif_edg_o=0, data_o=0, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0, state=IDLE, counters=0, synchronizer=1.
- IDLE:
  - On a falling edge: go to START, clear the bit counter, set verif_edg_o=1 on the next cycle.
  - Otherwise verif_edg_o=0.
- START:
  - Counter increments each cycle.
  - When counter==HALF_BIT-1 and rx_s=0: go to RECV.
  - When counter==HALF_BIT-1 and rx_s=1 (glitch): go to IDLE with verif_edg_o=0 on the next cycle. No error flag.
- RECV:
  - verif_edg_o held at 1.
  - On dato_compl_i=1, go to CHECK.
- CHECK (one cycle):
  - verif_edg_o=0, which clears the receiver.
  - If trama_i[0]=0 and trama_i[9]=1, the frame is good:
    - If valid_o=0, or valid_o&ready_i this same cycle: data_o<=trama_i[8:1], valid_o<=1.
    - Else: set overrun_o and drop the new byte; the old byte is kept.
  - Otherwise: set frame_err_o and drop the byte.
  - Next state is WAIT_IDLE.
- WAIT_IDLE:
  - verif_edg_o=0.
  - Stay until rx_s=1 (line idle; prevents re-trigger on a break), then go to IDLE.
- Handshake:
  - valid_o clears the cycle after valid_o&ready_i, unless CHECK loads a new byte in that same cycle, in which case valid_o stays 1.
  - data_o is stable while valid_o=1 and ready_i=0.
- Sticky flags:
  - Set in any state; cleared only by clr_err_i or rst_i.
  - If set and clear occur in the same cycle, set wins.
- Reset mid-frame: returns to IDLE within one cycle. verif_edg_o=0, any pending byte is lost, valid_o=0.
- busy_o = (state != IDLE), registered together with the state.

Optional Feature:
- Macro: UART_RX_SEQ_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in RECV, cleared on RECV entry.
  - If it reaches TIMEOUT_CYC-1 without dato_compl_i: verif_edg_o=0, frame_err_o set, go to WAIT_IDLE.
  - If dato_compl_i arrives on that same cycle, completion wins (goes to CHECK).
- Not defined: no counter; RECV waits indefinitely for dato_compl_i.

Test Plan:
- Reset, then rx_i held high for 50 cycles -> verif_edg_o=0, valid_o=0, busy_o=0, flags 0.
- rx_i low pulse of 4 cycles -> START entered, rejected at HALF_BIT; back in IDLE, verif_edg_o=0, no flags.
- Valid frame (10 bits, 16 cycles/bit) carrying 0xA5, ready_i=1 -> verif_edg_o high through RECV. After dato_compl_i, one-cycle valid_o with data_o=0xA5. frame_err_o=0.
- Frame with stop bit 0 (trama_i[9]=0) -> frame_err_o=1, valid_o stays 0. Then clr_err_i pulse -> frame_err_o=0 the next cycle.
- Two frames 0x3C then 0xC3, ready_i=0 throughout -> data_o=0x3C, valid_o=1, overrun_o=1. Then ready_i=1 for one cycle -> valid_o=0.
- With UART_RX_SEQ_TIMEOUT_EN defined and TIMEOUT_CYC=200: hold dato_compl_i=0 after a valid start -> at RECV cycle 199, verif_edg_o=0 and frame_err_o=1, then IDLE once rx_i is high. Also assert rst_i mid-RECV -> all outputs return to reset values the next cycle.
